// File: rtl/serial_cmp_ctrl.sv
// Bit-serial MSB-first magnitude comparator with a start/done handshake.
// Define SIGNED_CMP_EN to treat the operands as two's complement.
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_s, a_s_next;
  logic [WIDTH-1:0] b_s, b_s_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             lt_next, eq_next, gt_next;
  logic             a_msb, b_msb, flip;

  assign a_msb = a_s[WIDTH-1];
  assign b_msb = b_s[WIDTH-1];

`ifdef SIGNED_CMP_EN
  // A differing sign bit means the negative operand is the smaller one.
  assign flip = (idx == IDX_TOP);
`else
  assign flip = 1'b0;
`endif

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      a_s   <= '0;
      b_s   <= '0;
      idx   <= '0;
      lt    <= 1'b0;
      eq    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= state_next;
      a_s   <= a_s_next;
      b_s   <= b_s_next;
      idx   <= idx_next;
      lt    <= lt_next;
      eq    <= eq_next;
      gt    <= gt_next;
    end
  end

  always_comb begin
    state_next = state;
    a_s_next   = a_s;
    b_s_next   = b_s;
    idx_next   = idx;
    lt_next    = lt;
    eq_next    = eq;
    gt_next    = gt;
    ready      = (state == IDLE);
    busy       = (state == RUN);
    done       = (state == DONE);

    case (state)
      IDLE: begin
        if (start) begin
          a_s_next   = a_in;
          b_s_next   = b_in;
          idx_next   = IDX_TOP;
          lt_next    = 1'b0;
          eq_next    = 1'b0;
          gt_next    = 1'b0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (a_msb != b_msb) begin
          gt_next    = a_msb ^ flip;
          lt_next    = b_msb ^ flip;
          state_next = DONE;
        end else if (idx == '0) begin
          eq_next    = 1'b1;
          state_next = DONE;
        end else begin
          a_s_next = a_s << 1;
          b_s_next = b_s << 1;
          idx_next = idx - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// Scoreboard bench for serial_cmp_ctrl: a stimulus process pushes expected
// results and done times, a negedge monitor checks every cycle.
module tb_serial_cmp_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         RST_N;
  logic         start;
  logic [W-1:0] a_in, b_in;
  logic         ready, busy, done, lt, eq, gt;

  serial_cmp_ctrl #(.WIDTH(W)) dut (
    .CLOCK_50(clk), .RST_N(RST_N), .start(start), .a_in(a_in), .b_in(b_in),
    .ready(ready), .busy(busy), .done(done), .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] res;   // {lt, eq, gt}
    int         cyc;   // cycle count at which done is visible
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         dones = 0;
  logic [2:0] held = 3'b000;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: ordinary integer comparison; latency from the top differing bit.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input int acc);
    exp_t r;
    int   p = -1;
    for (int i = 0; i < W; i++)
      if (a[i] != b[i]) p = i;
`ifdef SIGNED_CMP_EN
    r.res = {($signed(a) < $signed(b)), (a == b), ($signed(a) > $signed(b))};
`else
    r.res = {(a < b), (a == b), (a > b)};
`endif
    r.cyc = acc + ((p < 0) ? W : (W - p));
    return r;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (RST_N) begin
      chk("onehot_state", $countones({ready, busy, done}), 1);
      if (busy) chk("run_results_zero", {lt, eq, gt}, 3'b000);
      if (ready) begin
        chk("held_results", {lt, eq, gt}, held);
        if (start) sb.push_back(model(a_in, b_in, cyc + 1));
      end
      if (done) begin
        dones++;
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("result", {lt, eq, gt}, e.res);
          chk("done_cycle", cyc, e.cyc);
          held = e.res;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ready && sb.size() == 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(ready && sb.size() == 0)) chk("idle_timeout", 0, 1);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    start = 1'b1; a_in = a; b_in = b;
    @(posedge clk); #1;
    start = 1'b0;
    a_in = W'($urandom); b_in = W'($urandom);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int d0;
    RST_N = 1'b0; start = 1'b0; a_in = '0; b_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", ready, 1);
    chk("reset_outputs", {busy, done, lt, eq, gt}, 5'b0);
    RST_N = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(8'h5A, 8'h5A); wait_idle();
    repeat (3) @(posedge clk);
    #1;
    issue(8'h12, 8'h13); wait_idle();
    issue(8'h13, 8'h12); wait_idle();
    issue(8'h80, 8'h7F); wait_idle();
    issue(8'h7F, 8'h80); wait_idle();

    // start while busy is ignored
    issue(8'h01, 8'h00);
    @(posedge clk); #1;
    start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // asynchronous reset in the third RUN cycle
    issue(8'h3C, 8'h3C);
    @(posedge clk); #1;
    @(posedge clk); #1;
    RST_N = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_outputs", {busy, done, lt, eq, gt}, 5'b0);
    sb.delete();
    held = 3'b000;
    @(posedge clk); #1;
    RST_N = 1'b1;
    issue(8'h00, 8'h01); wait_idle();

    // start held high: one compare every W+2 cycles
    wait_ready();
    d0 = dones;
    start = 1'b1; a_in = 8'hAA; b_in = 8'hAA;
    repeat (30) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk("held_start_dones", dones - d0, 3);

    // Randomized pairs, biased toward single-bit differences
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = W'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
      endcase
      issue(ra, rb);
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
